// File: rtl/knight_rider_pattern_checker.sv
// rtl/knight_rider_pattern_checker.sv - monitor that locks onto a bouncing one-hot LED sweep and counts illegal steps
// Optional stall timeout is built when KNIGHT_RIDER_STALL_TIMEOUT_EN is defined.
module knight_rider_pattern_checker #(
    parameter int WIDTH        = 8,
    parameter int POS_W        = $clog2(WIDTH),
    parameter int ERR_CNT_W    = 8,
    parameter int STALL_CYCLES = 50_000_000
) (
    input  logic                 clk_i,
    input  logic                 sys_rst_n_i,
    input  logic [WIDTH-1:0]     pattern_i,
    output logic [POS_W-1:0]     pos_o,
    output logic                 dir_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 stall_o
);

    localparam int HOT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ACQ1, ACQ2, TRACK} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [HOT_W-1:0]     hot_cnt;
    logic [POS_W-1:0]     idx;
    logic                 onehot;
    logic                 step;
    logic [POS_W-1:0]     succ_pos;
    logic                 succ_dir;
    logic                 adj_up;
    logic                 adj_dn;
    logic                 raise_err;
    logic                 stall_fire;

    always_comb begin
        hot_cnt = '0;
        idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pattern_i[i]) begin
                hot_cnt = hot_cnt + HOT_W'(1);
                idx     = POS_W'(i);
            end
        end
    end

    assign onehot = (hot_cnt == HOT_W'(1));
    assign step   = (pattern_i != prev_q);

    // Endpoints reflect the sweep instead of wrapping around.
    always_comb begin
        succ_pos = pos_q;
        succ_dir = dir_q;
        if (!dir_q) begin
            if (pos_q == POS_W'(WIDTH - 1)) begin
                succ_pos = POS_W'(WIDTH - 2);
                succ_dir = 1'b1;
            end else begin
                succ_pos = pos_q + POS_W'(1);
            end
        end else begin
            if (pos_q == '0) begin
                succ_pos = POS_W'(1);
                succ_dir = 1'b0;
            end else begin
                succ_pos = pos_q - POS_W'(1);
            end
        end
    end

    assign adj_up = (pos_q != POS_W'(WIDTH - 1)) && (idx == pos_q + POS_W'(1));
    assign adj_dn = (pos_q != '0) && (idx == pos_q - POS_W'(1));

`ifdef KNIGHT_RIDER_STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_q, stall_d;

    assign stall_fire  = (state_q == TRACK) && !step &&
                         (stall_cnt_q == STALL_W'(STALL_CYCLES - 1));
    assign stall_cnt_d = ((state_q == TRACK) && !step && !stall_fire) ?
                         stall_cnt_q + STALL_W'(1) : '0;

    always_comb begin
        stall_d = stall_q;
        if (step) begin
            stall_d = 1'b0;
        end else if (stall_fire) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sys_rst_n_i) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign stall_o = stall_q;
`else
    assign stall_fire = 1'b0;
    assign stall_o    = 1'b0 & (STALL_CYCLES > 0);
`endif

    always_comb begin
        state_d   = state_q;
        prev_d    = pattern_i;
        pos_d     = pos_q;
        dir_d     = dir_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        raise_err = 1'b0;

        if (step) begin
            case (state_q)
                ACQ1: begin
                    if (onehot) begin
                        pos_d   = idx;
                        state_d = ACQ2;
                    end
                end
                ACQ2: begin
                    if (!onehot) begin
                        state_d = ACQ1;
                    end else if (adj_up) begin
                        pos_d   = idx;
                        dir_d   = 1'b0;
                        state_d = TRACK;
                    end else if (adj_dn) begin
                        pos_d   = idx;
                        dir_d   = 1'b1;
                        state_d = TRACK;
                    end else begin
                        pos_d = idx;
                    end
                end
                TRACK: begin
                    if (onehot && (idx == succ_pos)) begin
                        pos_d = succ_pos;
                        dir_d = succ_dir;
                    end else begin
                        raise_err = 1'b1;
                        if (onehot) begin
                            pos_d   = idx;
                            state_d = ACQ2;
                        end else begin
                            state_d = ACQ1;
                        end
                    end
                end
                default: state_d = ACQ1;
            endcase
        end else if (stall_fire) begin
            raise_err = 1'b1;
            state_d   = ACQ2;
        end

        if (raise_err) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= ACQ1;
            prev_q    <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pos_o     = pos_q;
    assign dir_o     = dir_q;
    assign locked_o  = (state_q == TRACK);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_knight_rider_pattern_checker.sv
// tb/tb_knight_rider_pattern_checker.sv - self-checking bench for knight_rider_pattern_checker
module tb_knight_rider_pattern_checker;

    localparam int W     = 8;
    localparam int STALL = 16;
    localparam int MAXC  = 255;

    logic       clk;
    logic       sys_rst_n;
    logic [7:0] pattern;
    logic [2:0] pos;
    logic       dir;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       stall;

    int checks = 0;
    int errors = 0;

    knight_rider_pattern_checker #(
        .WIDTH(W),
        .ERR_CNT_W(8),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk_i(clk),
        .sys_rst_n_i(sys_rst_n),
        .pattern_i(pattern),
        .pos_o(pos),
        .dir_o(dir),
        .locked_o(locked),
        .err_o(err),
        .err_cnt_o(err_cnt),
        .stall_o(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = hunting, 1 = one reference seen, 2 = locked.
    int m_mode, m_pos, m_dir, m_cnt, m_err, m_stall, m_scnt, m_prev;
    bit m_valid = 1'b0;

    task automatic model_edge();
        int ones, at, ph, span;
        bit good;
        if (!sys_rst_n) begin
            m_mode = 0; m_pos = 0; m_dir = 0; m_cnt = 0;
            m_err = 0; m_stall = 0; m_scnt = 0; m_prev = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        ones = 0; at = 0;
        for (int i = 0; i < W; i++) if (pattern[i]) begin ones++; at = i; end
        m_err = 0;
        good = 1'b0;
        if (int'(pattern) != m_prev) begin
            m_stall = 0;
            m_scnt  = 0;
            if (m_mode == 0) begin
                if (ones == 1) begin m_pos = at; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (ones != 1) m_mode = 0;
                else if (at == m_pos + 1) begin m_pos = at; m_dir = 0; m_mode = 2; end
                else if (at == m_pos - 1) begin m_pos = at; m_dir = 1; m_mode = 2; end
                else m_pos = at;
            end else begin
                // Position on the sweep cycle as a phase 0 .. 2*(W-1)-1.
                span = 2 * (W - 1);
                ph = m_dir ? span - m_pos : m_pos;
                ph = (ph + 1) % span;
                if (ones == 1 && at == ((ph <= W - 1) ? ph : span - ph)) begin
                    m_pos = at;
                    m_dir = (ph >= W || ph == 0) ? 1 : 0;
                    good = 1'b1;
                end
                if (!good) begin
                    m_err = 1;
                    m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
                    if (ones == 1) begin m_pos = at; m_mode = 1; end
                    else m_mode = 0;
                end
            end
        end else begin
`ifdef KNIGHT_RIDER_STALL_TIMEOUT_EN
            if (m_mode == 2) begin
                m_scnt++;
                if (m_scnt == STALL) begin
                    m_stall = 1; m_err = 1; m_scnt = 0; m_mode = 1;
                    m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
                end
            end else begin
                m_scnt = 0;
            end
`endif
        end
        m_prev = int'(pattern);
    endtask

    always begin
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            checks++;
            if (int'(pos) != m_pos || int'(dir) != m_dir || int'(locked) != (m_mode == 2 ? 1 : 0) ||
                int'(err) != m_err || int'(err_cnt) != m_cnt || int'(stall) != m_stall) begin
                errors++;
                $display("FAIL model t=%0t pos=%0d/%0d dir=%0d/%0d locked=%0d/%0d err=%0d/%0d cnt=%0d/%0d stall=%0d/%0d",
                         $time, pos, m_pos, dir, m_dir, locked, (m_mode == 2), err, m_err,
                         err_cnt, m_cnt, stall, m_stall);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] p, input int n);
        pattern = p;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] sw_pat [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    int         sw_pos [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int         sw_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        sys_rst_n = 1'b0;
        pattern   = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pos", int'(pos), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt", int'(err_cnt), 0);
        chk("rst_stall", int'(stall), 0);

        sys_rst_n = 1'b1;
        drive(8'h00, 4);
        chk("idle_locked", int'(locked), 0);
        chk("idle_err", int'(err), 0);

        for (int i = 0; i < 16; i++) begin
            drive(sw_pat[i], 1);
            if (i == 1) chk("lock_after_02", int'(locked), 1);
            drive(sw_pat[i], 3);
            chk("sweep_pos", int'(pos), sw_pos[i]);
            chk("sweep_dir", int'(dir), sw_dir[i]);
            chk("sweep_cnt", int'(err_cnt), 0);
        end

        drive(8'h04, 4);
        drive(8'h08, 4);
        drive(8'h20, 1);
        chk("skip_err", int'(err), 1);
        chk("skip_cnt", int'(err_cnt), 1);
        chk("skip_locked", int'(locked), 0);
        chk("skip_pos", int'(pos), 5);
        drive(8'h20, 1);
        chk("skip_err_pulse", int'(err), 0);
        drive(8'h20, 2);
        drive(8'h40, 1);
        chk("relock_locked", int'(locked), 1);
        chk("relock_dir", int'(dir), 0);
        chk("relock_pos", int'(pos), 6);
        drive(8'h40, 3);

        drive(8'h18, 1);
        chk("multi_err", int'(err), 1);
        chk("multi_cnt", int'(err_cnt), 2);
        chk("multi_pos", int'(pos), 6);
        chk("multi_locked", int'(locked), 0);
        drive(8'h18, 3);
        drive(8'h02, 4);
        drive(8'h04, 4);
        chk("multi_relock", int'(locked), 1);
        chk("multi_relock_dir", int'(dir), 0);

        drive(8'h08, 4); drive(8'h10, 4); drive(8'h20, 4); drive(8'h40, 4); drive(8'h80, 4);
        drive(8'h01, 1);
        chk("wrap_err", int'(err), 1);
        chk("wrap_cnt", int'(err_cnt), 3);
        chk("wrap_pos", int'(pos), 0);
        drive(8'h01, 3);
        drive(8'h02, 2);

        for (int i = 0; i < 300; i++) begin
            drive(8'h00, 1);
            if (i == 0) chk("sat_first", int'(err_cnt), 4);
            if (i == 299) begin
                chk("sat_err", int'(err), 1);
                chk("sat_cnt", int'(err_cnt), 255);
            end
            drive(8'h00, 1);
            drive(8'h01, 2);
            drive(8'h02, 2);
        end
        chk("sat_hold", int'(err_cnt), 255);

        drive(8'h04, 4);
        drive(8'h08, 4);
`ifdef KNIGHT_RIDER_STALL_TIMEOUT_EN
        drive(8'h10, STALL);
        chk("stall_before", int'(stall), 0);
        chk("stall_before_lock", int'(locked), 1);
        drive(8'h10, 1);
        chk("stall_flag", int'(stall), 1);
        chk("stall_err", int'(err), 1);
        chk("stall_locked", int'(locked), 0);
        chk("stall_pos", int'(pos), 4);
        drive(8'h10, 3);
        chk("stall_hold", int'(stall), 1);
        chk("stall_err_pulse", int'(err), 0);
`else
        drive(8'h10, 20);
        chk("nostall_flag", int'(stall), 0);
        chk("nostall_locked", int'(locked), 1);
        chk("nostall_err", int'(err), 0);
`endif
        drive(8'h20, 1);
        chk("after_stall_flag", int'(stall), 0);
        chk("after_stall_locked", int'(locked), 1);
        chk("after_stall_pos", int'(pos), 5);
        drive(8'h20, 3);
        drive(8'h40, 2);

        sys_rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pos", int'(pos), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_cnt", int'(err_cnt), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_stall", int'(stall), 0);
        sys_rst_n = 1'b1;
        drive(8'h00, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
